// File: rtl/alu_flag_pkg.sv
// Shared types for the ALU flag stage: ALU opcodes, flag bit positions
// and the skid-buffer occupancy states.
package alu_flag_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_XOR = 2'b10,
        OP_NOT = 2'b11
    } alu_op_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } state_e;

endpackage

// File: rtl/alu_flag_stage_flag_calc.sv
// flag_calc: combinational N/Z/C/V derivation for one ALU result.
// In: alu_control, a_msb, b_msb, alu_out[N-1:0], alu_cout. Out: flags[3:0].
module flag_calc
    import alu_flag_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [1:0]   alu_control,
    input  logic         a_msb,
    input  logic         b_msb,
    input  logic [N-1:0] alu_out,
    input  logic         alu_cout,
    output logic [3:0]   flags
);

    logic r_msb;

    assign r_msb = alu_out[N-1];

    always_comb begin
        flags         = '0;
        flags[FLAG_N] = r_msb;
        flags[FLAG_Z] = (alu_out == '0);
        unique case (alu_op_e'(alu_control))
            OP_ADD: begin
                flags[FLAG_C] = alu_cout;
                flags[FLAG_V] = (a_msb == b_msb) && (r_msb != a_msb);
            end
            OP_SUB: begin
                // Carry set means no borrow occurred.
                flags[FLAG_C] = alu_cout;
                flags[FLAG_V] = (a_msb != b_msb) && (r_msb != a_msb);
            end
            OP_XOR, OP_NOT: begin
                flags[FLAG_C] = 1'b0;
                flags[FLAG_V] = 1'b0;
            end
            default: begin
                flags[FLAG_C] = 1'b0;
                flags[FLAG_V] = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_flag_stage.sv
// Registered execute-output stage: captures ALU result plus flags behind a
// valid/ready handshake with a 2-entry skid buffer, and holds the
// architectural flag register updated when a set_flags beat retires.
// In:  clk, rst (sync, active-low), in_valid, alu_control, a_msb, b_msb,
//      alu_out, alu_cout, set_flags, out_ready.
// Out: in_ready, out_valid, out_result, out_flags, flags_q.
module alu_flag_stage
    import alu_flag_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   alu_control,
    input  logic         a_msb,
    input  logic         b_msb,
    input  logic [N-1:0] alu_out,
    input  logic         alu_cout,
    input  logic         set_flags,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output logic [3:0]   out_flags,
    output logic [3:0]   flags_q
);

    state_e       state_q;
    logic [N-1:0] m_res_q;
    logic [3:0]   m_flags_q;
    logic         m_set_q;
    logic [N-1:0] s_res_q;
    logic [3:0]   s_flags_q;
    logic         s_set_q;

    logic [3:0]   beat_flags;
    logic         accept;
    logic         pop;

    flag_calc #(
        .N(N)
    ) u_flag_calc (
        .alu_control(alu_control),
        .a_msb      (a_msb),
        .b_msb      (b_msb),
        .alu_out    (alu_out),
        .alu_cout   (alu_cout),
        .flags      (beat_flags)
    );

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready   = (state_q != TWO) && rst;
    assign out_valid  = (state_q != EMPTY);
    assign out_result = m_res_q;
    assign out_flags  = m_flags_q;

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= EMPTY;
            m_res_q   <= '0;
            m_flags_q <= '0;
            m_set_q   <= 1'b0;
            s_res_q   <= '0;
            s_flags_q <= '0;
            s_set_q   <= 1'b0;
            flags_q   <= '0;
        end else begin
            if (pop && m_set_q) begin
                flags_q <= m_flags_q;
            end
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        m_res_q   <= alu_out;
                        m_flags_q <= beat_flags;
                        m_set_q   <= set_flags;
                        state_q   <= ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        m_res_q   <= alu_out;
                        m_flags_q <= beat_flags;
                        m_set_q   <= set_flags;
                    end else if (accept) begin
                        s_res_q   <= alu_out;
                        s_flags_q <= beat_flags;
                        s_set_q   <= set_flags;
                        state_q   <= TWO;
                    end else if (pop) begin
                        state_q   <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        m_res_q   <= s_res_q;
                        m_flags_q <= s_flags_q;
                        m_set_q   <= s_set_q;
                        state_q   <= ONE;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_flag_stage.sv
// Directed testbench for alu_flag_stage (N=4).
// Each task drives one scenario and checks outputs 1ns after the clock edge.
module tb_alu_flag_stage;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] alu_control;
    logic       a_msb;
    logic       b_msb;
    logic [3:0] alu_out;
    logic       alu_cout;
    logic       set_flags;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic [3:0] out_flags;
    logic [3:0] flags_q;

    int checks;
    int errors;

    alu_flag_stage #(
        .N(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_control(alu_control),
        .a_msb      (a_msb),
        .b_msb      (b_msb),
        .alu_out    (alu_out),
        .alu_cout   (alu_cout),
        .set_flags  (set_flags),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .flags_q    (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic am,
                         input logic bm, input logic [3:0] res,
                         input logic co, input logic sf);
        alu_control = op;
        a_msb       = am;
        b_msb       = bm;
        alu_out     = res;
        alu_cout    = co;
        set_flags   = sf;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        step(); step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid);
        end
        checks++;
        if (out_result !== 4'h0 || out_flags !== 4'h0) begin
            errors++;
            $display("FAIL rst_out got %h/%h exp 0/0", out_result, out_flags);
        end
        checks++;
        if (flags_q !== 4'h0) begin
            errors++; $display("FAIL rst_flags_q got %b exp 0000", flags_q);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL post_rst_in_ready got %b exp 1", in_ready);
        end
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        drive(2'b00, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_result !== 4'b1000) begin
            errors++;
            $display("FAIL add_result got v=%b %b exp v=1 1000",
                     out_valid, out_result);
        end
        checks++;
        if (out_flags !== 4'b1001) begin
            errors++; $display("FAIL add_flags got %b exp 1001", out_flags);
        end
        checks++;
        if (flags_q !== 4'b0000) begin
            errors++; $display("FAIL add_flags_q_early got %b exp 0000", flags_q);
        end
        step();
        checks++;
        if (flags_q !== 4'b1001 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_retire got flags_q=%b v=%b exp 1001 v=0",
                     flags_q, out_valid);
        end
    endtask

    task automatic test_sub_xor();
        out_ready = 1'b1;
        drive(2'b01, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
        in_valid = 1'b1;
        step();
        checks++;
        if (out_flags !== 4'b0110) begin
            errors++; $display("FAIL sub_flags got %b exp 0110", out_flags);
        end
        // XOR accepted in the same edge the SUB retires.
        drive(2'b10, 1'b0, 1'b0, 4'b0110, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        checks++;
        if (flags_q !== 4'b0110) begin
            errors++; $display("FAIL sub_retire got %b exp 0110", flags_q);
        end
        checks++;
        if (out_result !== 4'b0110 || out_flags !== 4'b0000) begin
            errors++;
            $display("FAIL xor_beat got %b/%b exp 0110/0000",
                     out_result, out_flags);
        end
        step();
        checks++;
        if (flags_q !== 4'b0110 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL xor_noset got flags_q=%b v=%b exp 0110 v=0",
                     flags_q, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(2'b10, 1'b0, 1'b0, 4'h1, 1'b0, 1'b0);
        step();
        checks++;
        if (in_ready !== 1'b1 || out_result !== 4'h1) begin
            errors++;
            $display("FAIL b2b_first got rdy=%b res=%h exp 1 1",
                     in_ready, out_result);
        end
        drive(2'b10, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0);
        step();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_full_ready got %b exp 0", in_ready);
        end
        drive(2'b10, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0);
        step();
        checks++;
        if (in_ready !== 1'b0 || out_result !== 4'h1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_hold got rdy=%b res=%h v=%b exp 0 1 1",
                     in_ready, out_result, out_valid);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_result !== 4'h2 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second got res=%h rdy=%b exp 2 1",
                     out_result, in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_result !== 4'h3 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_third got res=%h v=%b exp 3 1",
                     out_result, out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || flags_q !== 4'b0110) begin
            errors++;
            $display("FAIL b2b_drain got v=%b flags_q=%b exp 0 0110",
                     out_valid, flags_q);
        end
    endtask

    task automatic test_stream();
        logic [3:0] exp_f;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(2'b00, 1'b0, 1'b0, 4'(i), 1'b0, 1'b1);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL stream_ready[%0d] got %b exp 1", i, in_ready);
            end
            step();
            // a=b=0 msb: N=V=result msb, Z on zero, C=0 since cout=0.
            exp_f = {i[3], (i == 0), 1'b0, i[3]};
            checks++;
            if (out_valid !== 1'b1 || out_result !== 4'(i) || out_flags !== exp_f) begin
                errors++;
                $display("FAIL stream_beat[%0d] got v=%b %h/%b exp 1 %h/%b",
                         i, out_valid, out_result, out_flags, 4'(i), exp_f);
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (flags_q !== 4'b1001) begin
            errors++; $display("FAIL stream_flags_q got %b exp 1001", flags_q);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(2'b10, 1'b0, 1'b0, 4'h5, 1'b0, 1'b1);
        step();
        drive(2'b10, 1'b0, 1'b0, 4'h6, 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_result !== 4'h5) begin
            errors++;
            $display("FAIL mid_two got rdy=%b res=%h exp 0 5", in_ready, out_result);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        rst = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || flags_q !== 4'b0000 || out_result !== 4'h0) begin
            errors++;
            $display("FAIL mid_reset got v=%b flags_q=%b res=%h exp 0 0000 0",
                     out_valid, flags_q, out_result);
        end
        drive(2'b00, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_result !== 4'h0 || out_flags !== 4'b0111) begin
            errors++;
            $display("FAIL mid_first got v=%b %h/%b exp 1 0/0111",
                     out_valid, out_result, out_flags);
        end
        step();
        checks++;
        if (flags_q !== 4'b0111 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_retire got flags_q=%b v=%b exp 0111 0",
                     flags_q, out_valid);
        end
    endtask

    task automatic test_not();
        out_ready = 1'b1;
        drive(2'b11, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_result !== 4'b1111 || out_flags !== 4'b1000) begin
            errors++;
            $display("FAIL not_beat got %b/%b exp 1111/1000", out_result, out_flags);
        end
        step();
        checks++;
        if (flags_q !== 4'b1000) begin
            errors++; $display("FAIL not_flags_q got %b exp 1000", flags_q);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add();
        test_sub_xor();
        test_back_to_back();
        test_stream();
        test_reset_mid();
        test_not();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_flag_stage.md
Name: alu_flag_stage

Overview:
- Registered execute-output stage directly downstream of the flagless ALU.
- Captures the ALU result and carry-out, and derives per-result N/Z/C/V flags from the operand MSBs and the ALU operation.
- Holds the architectural flag register.
- Decouples the ALU from writeback with a valid/ready handshake and a 2-entry skid buffer, so it sustains 1 result/cycle under backpressure.

Parameters:
N, 4, data width of ALU result and operands.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  reset, synchronous and active-low.
in_valid  in  1  ALU beat presented this cycle.
in_ready  out  1  stage can accept a beat.
alu_control  in  2  ALU op of the beat: 00 ADD, 01 SUB, 10 XOR, 11 NOT.
a_msb  in  1  A[N-1] of the beat.
b_msb  in  1  B[N-1] of the beat.
alu_out  in  N  ALU result.
alu_cout  in  1  ALU carry-out.
set_flags  in  1  beat updates the architectural flags when retired.
out_valid  out  1  result beat available.
out_ready  in  1  consumer accepts the beat.
out_result  out  N  registered result.
out_flags  out  4  per-beat flags {N,Z,C,V}, bit3=N ... bit0=V.
flags_q  out  4  architectural flags {N,Z,C,V}.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state EMPTY; out_valid=0, out_result=0, out_flags=0, flags_q=0.
  - in_ready=0 while rst=0.
  - Reset mid-operation discards both buffered beats with no flag update.
- accept = in_valid & in_ready. pop = out_valid & out_ready.
- Flags computed combinationally on accept, stored with the beat:
  - N = alu_out[N-1].
  - Z = (alu_out == 0).
  - C = alu_cout for ADD/SUB. SUB carry=1 means no borrow. C = 0 for XOR/NOT.
  - V for ADD = (a_msb==b_msb) & (alu_out[N-1]!=a_msb).
  - V for SUB = (a_msb!=b_msb) & (alu_out[N-1]!=a_msb).
  - V = 0 for XOR/NOT.
- Storage: main reg M drives the outputs; skid reg S. Each entry holds result, flags and set_flags.
- States: EMPTY (none), ONE (M valid), TWO (M and S valid).
  - EMPTY: accept -> M<=beat, ONE.
  - ONE: accept&pop -> M<=beat, stay ONE. accept&!pop -> S<=beat, TWO. pop&!accept -> EMPTY.
  - TWO: pop -> M<=S, ONE. No pop -> hold.
- in_ready = (state!=TWO) & rst. It is a function of registered state only, with no combinational path from out_ready.
- out_valid = (state!=EMPTY). out_result/out_flags come from M.
- Latency: an accepted beat appears on the outputs the next cycle when the stage was EMPTY or popping.
- Ordering: strictly FIFO; no beat is dropped or duplicated.
- Architectural flags:
  - On pop with M.set_flags=1, flags_q <= M.flags at that edge.
  - On pop with M.set_flags=0, flags_q holds.
  - flags_q never changes without a pop.
- Simultaneous accept and pop in ONE: the retiring beat updates flags_q and the new beat loads M in the same edge.
- out_result/out_flags are stable while out_valid=1 and out_ready=0.
- Width: all arithmetic is N bits. Z is computed over exactly N bits.

Decomposition:
- Package alu_flag_pkg:
  - op enum {OP_ADD=2'b00, OP_SUB=2'b01, OP_XOR=2'b10, OP_NOT=2'b11}.
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - State enum {EMPTY, ONE, TWO}.
- Sub-module flag_calc (combinational, parameter N): inputs alu_control, a_msb, b_msb, alu_out, alu_cout; output flags[3:0]. It is reused by any future flag consumer.

Test Plan:
1. Reset then ADD, N=4, A=0111 B=0001 (alu_out=1000, cout=0, set_flags=1), out_ready=1 -> next cycle out_result=1000, out_flags=1001; flags_q=1001 after pop.
2. SUB 0011-0011 (alu_out=0000, cout=1) -> out_flags=0110. XOR beat with set_flags=0 after it -> flags_q stays 0110.
3. out_ready=0, push 3 beats back-to-back -> first two accepted, in_ready=0 from the cycle after the 2nd accept, 3rd held. Release out_ready -> beats emerge in order, one per cycle, none lost.
4. Continuous in_valid=1/out_ready=1 for 16 beats -> in_ready stays 1, throughput 1 beat/cycle, latency 1.
5. State TWO, assert rst=0 for one cycle -> out_valid=0, flags_q=0000, buffered beats discarded. First beat after reset is accepted normally.
6. NOT with B=0000 (alu_out=1111, cout=1 ignored) -> out_flags=1000 (C=0, V=0).
